// File: rtl/sw_score_tracker_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// sw_score_tracker_if : beat input / query result bundle for sw_score_tracker
// Rev 1.0
//------------------------------------------------------------------------------
interface sw_score_tracker_if #(
   parameter int NUM_PE  = 64,
   parameter int SCORE_W = 16,
   parameter int CYC_W   = 16
);
   localparam int LW = $clog2(NUM_PE);

   logic                      in_valid;
   logic                      in_first;
   logic                      in_last;
   logic [NUM_PE-1:0]         lane_en;
   logic [NUM_PE*SCORE_W-1:0] score;
   logic                      best_valid;
   logic [SCORE_W-1:0]        best_score;
   logic [LW-1:0]             best_lane;
   logic [CYC_W-1:0]          best_cycle;
   logic                      busy;

   modport master (
      output in_valid, in_first, in_last, lane_en, score,
      input  best_valid, best_score, best_lane, best_cycle, busy
   );

   modport slave (
      input  in_valid, in_first, in_last, lane_en, score,
      output best_valid, best_score, best_lane, best_cycle, busy
   );
endinterface
`default_nettype wire

// File: rtl/sw_score_tracker.sv
`default_nettype none
//------------------------------------------------------------------------------
// sw_score_tracker : pipelined max tree over NUM_PE lanes with per-query best tracking
// Rev 1.0
//------------------------------------------------------------------------------
module sw_score_tracker #(
   parameter int NUM_PE  = 64,
   parameter int SCORE_W = 16,
   parameter int CYC_W   = 16
) (
   input  wire logic        clk,
   input  wire logic        rst,
   sw_score_tracker_if.slave bus
);
   localparam int L  = $clog2(NUM_PE);
   localparam int NN = NUM_PE - 1;
   localparam logic [CYC_W-1:0] C_CYC_MAX = '1;

   logic [SCORE_W-1:0] w_leaf_sc [NUM_PE];
   logic [L-1:0]       w_leaf_ln [NUM_PE];
   logic [SCORE_W-1:0] w_nd_sc   [NN];
   logic [L-1:0]       w_nd_ln   [NN];

   logic [L-1:0]       r_vld;
   logic [L-1:0]       r_fst;
   logic [L-1:0]       r_lst;
   logic [CYC_W-1:0]   r_cyc [L];
   logic [CYC_W-1:0]   r_cnt;
   logic [CYC_W-1:0]   w_beat;
   logic               r_open;

   logic [SCORE_W-1:0] r_acc_sc, r_best_sc;
   logic [L-1:0]       r_acc_ln, r_best_ln;
   logic [CYC_W-1:0]   r_acc_cyc, r_best_cyc;
   logic               r_best_vld;
   logic               w_take;
   logic [SCORE_W-1:0] w_nxt_sc;
   logic [L-1:0]       w_nxt_ln;
   logic [CYC_W-1:0]   w_nxt_cyc;

   genvar gi;
   for (gi = 0; gi < NUM_PE; gi++) begin : g_leaf
      assign w_leaf_sc[gi] = bus.lane_en[gi] ? bus.score[gi*SCORE_W +: SCORE_W] : '0;
      assign w_leaf_ln[gi] = L'(gi);
   end

   // Heap-ordered tree: node n has children 2n+1 / 2n+2; indices >= NN are leaves.
   // The left child always covers lower lanes, so "right only if strictly greater" gives lowest-lane ties.
   for (gi = 0; gi < NN; gi++) begin : g_node
      logic [SCORE_W-1:0] w_a_sc, w_b_sc, r_sc;
      logic [L-1:0]       w_a_ln, w_b_ln, r_ln;
      if (2*gi+1 >= NN) begin : g_from_leaf
         assign w_a_sc = w_leaf_sc[2*gi+1-NN];
         assign w_a_ln = w_leaf_ln[2*gi+1-NN];
         assign w_b_sc = w_leaf_sc[2*gi+2-NN];
         assign w_b_ln = w_leaf_ln[2*gi+2-NN];
      end else begin : g_from_node
         assign w_a_sc = w_nd_sc[2*gi+1];
         assign w_a_ln = w_nd_ln[2*gi+1];
         assign w_b_sc = w_nd_sc[2*gi+2];
         assign w_b_ln = w_nd_ln[2*gi+2];
      end
      always_ff @(posedge clk) begin
         if (w_b_sc > w_a_sc) begin
            r_sc <= w_b_sc;
            r_ln <= w_b_ln;
         end else begin
            r_sc <= w_a_sc;
            r_ln <= w_a_ln;
         end
      end
      assign w_nd_sc[gi] = r_sc;
      assign w_nd_ln[gi] = r_ln;
   end

   always_comb begin
      w_beat = '0;
      if (!bus.in_first)
         w_beat = (r_cnt == C_CYC_MAX) ? r_cnt : r_cnt + CYC_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_vld  <= '0;
         r_fst  <= '0;
         r_lst  <= '0;
         r_cnt  <= '0;
         r_open <= 1'b0;
         for (int s = 0; s < L; s++) r_cyc[s] <= '0;
      end else begin
         r_vld[0] <= bus.in_valid;
         r_fst[0] <= bus.in_first;
         r_lst[0] <= bus.in_last;
         r_cyc[0] <= w_beat;
         for (int s = 1; s < L; s++) begin
            r_vld[s] <= r_vld[s-1];
            r_fst[s] <= r_fst[s-1];
            r_lst[s] <= r_lst[s-1];
            r_cyc[s] <= r_cyc[s-1];
         end
         if (bus.in_valid) begin
            r_cnt <= w_beat;
            if (bus.in_first)
               r_open <= ~bus.in_last;
            else if (bus.in_last)
               r_open <= 1'b0;
         end
      end
   end

   assign w_take    = r_fst[L-1] || (w_nd_sc[0] > r_acc_sc);
   assign w_nxt_sc  = w_take ? w_nd_sc[0]   : r_acc_sc;
   assign w_nxt_ln  = w_take ? w_nd_ln[0]   : r_acc_ln;
   assign w_nxt_cyc = w_take ? r_cyc[L-1]   : r_acc_cyc;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc_sc   <= '0;
         r_acc_ln   <= '0;
         r_acc_cyc  <= '0;
         r_best_sc  <= '0;
         r_best_ln  <= '0;
         r_best_cyc <= '0;
         r_best_vld <= 1'b0;
      end else begin
         r_best_vld <= 1'b0;
         if (r_vld[L-1]) begin
            r_acc_sc  <= w_nxt_sc;
            r_acc_ln  <= w_nxt_ln;
            r_acc_cyc <= w_nxt_cyc;
            if (r_lst[L-1]) begin
               r_best_sc  <= w_nxt_sc;
               r_best_ln  <= w_nxt_ln;
               r_best_cyc <= w_nxt_cyc;
               r_best_vld <= 1'b1;
            end
         end
      end
   end

   assign bus.best_valid = r_best_vld;
   assign bus.best_score = r_best_sc;
   assign bus.best_lane  = r_best_ln;
   assign bus.best_cycle = r_best_cyc;
   assign bus.busy       = r_open | (|r_vld);
endmodule
`default_nettype wire

// File: tb/tb_sw_score_tracker.sv
`default_nettype none
//------------------------------------------------------------------------------
// tb_sw_score_tracker : table vectors, corner sequences and random beats vs a query-level model
// Rev 1.0
//------------------------------------------------------------------------------
module tb_sw_score_tracker;
   localparam int NP = 8;
   localparam int SW = 8;
   localparam int CW = 4;
   localparam int LAT = 3;

   logic clk = 1'b0;
   logic rst;
   int   edge_cnt = 0;

   always #5 clk = ~clk;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   sw_score_tracker_if #(.NUM_PE(NP), .SCORE_W(SW), .CYC_W(CW)) bus ();
   sw_score_tracker #(.NUM_PE(NP), .SCORE_W(SW), .CYC_W(CW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   typedef struct { int due; int s; int l; int c; } res_t;
   typedef struct { logic [7:0] en; logic [63:0] sc; int es; int el; } vec_t;

   res_t q[$];
   res_t m_best;
   int   acc_s, acc_l, acc_c, mcnt, last_v_edge;
   bit   m_open, seen_bv;
   int   bv_count = 0;
   int   total = 0;
   int   bad = 0;

   function automatic logic [63:0] pk(input int s0, s1, s2, s3, s4, s5, s6, s7);
      return {8'(s7), 8'(s6), 8'(s5), 8'(s4), 8'(s3), 8'(s2), 8'(s1), 8'(s0)};
   endfunction

   function automatic logic [63:0] fill(input int v);
      return pk(v, v, v, v, v, v, v, v);
   endfunction

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_cnt);
      end
   endtask

   task automatic model_reset();
      q.delete();
      acc_s = 0; acc_l = 0; acc_c = 0; mcnt = 0;
      m_open = 0; last_v_edge = -100;
      m_best = '{0, 0, 0, 0};
   endtask

   // Query-level view: a beat's effect on the query maximum is decided when it is offered;
   // the commit appears LAT edges after the last beat is sampled.
   task automatic model_beat(input bit f, input bit l, input logic [7:0] en,
                             input logic [63:0] sc, input int e);
      int bs, bl, bc, v;
      bs = en[0] ? int'(sc[7:0]) : 0;
      bl = 0;
      for (int i = 1; i < NP; i++) begin
         v = en[i] ? int'(sc[i*8 +: 8]) : 0;
         if (v > bs) begin bs = v; bl = i; end
      end
      bc = f ? 0 : ((mcnt < 15) ? mcnt + 1 : 15);
      mcnt = bc;
      if (f || bs > acc_s) begin acc_s = bs; acc_l = bl; acc_c = bc; end
      if (l) q.push_back('{e + LAT, acc_s, acc_l, acc_c});
      if (f) m_open = !l;
      else if (l) m_open = 0;
      last_v_edge = e;
   endtask

   task automatic check();
      bit bv_exp;
      bv_exp = (q.size() > 0) && (q[0].due == edge_cnt);
      cmp("best_valid", 32'(bus.best_valid), 32'(bv_exp));
      seen_bv = (bus.best_valid === 1'b1);
      if (seen_bv) bv_count++;
      if (bv_exp) m_best = q.pop_front();
      cmp("best_score", 32'(bus.best_score), m_best.s);
      cmp("best_lane", 32'(bus.best_lane), m_best.l);
      cmp("best_cycle", 32'(bus.best_cycle), m_best.c);
      cmp("busy", 32'(bus.busy), 32'(m_open || (last_v_edge > edge_cnt - LAT)));
   endtask

   task automatic cycle(input bit r, input bit v, input bit f, input bit l,
                        input logic [7:0] en, input logic [63:0] sc);
      @(negedge clk);
      check();
      rst = r;
      bus.in_valid = v; bus.in_first = f; bus.in_last = l;
      bus.lane_en = en; bus.score = sc;
      if (r) model_reset();
      else if (v) model_beat(f, l, en, sc, edge_cnt + 1);
   endtask

   task automatic idle();
      cycle(0, 0, 0, 0, 8'h00, 64'h0);
   endtask

   task automatic wait_result(input string name, input int es, input int el, input int ec);
      bit got = 0;
      for (int i = 0; i < 8 && !got; i++) begin
         idle();
         if (seen_bv) got = 1;
      end
      cmp({name, "_pulse"}, 32'(got), 1);
      cmp({name, "_score"}, 32'(bus.best_score), es);
      cmp({name, "_lane"}, 32'(bus.best_lane), el);
      cmp({name, "_cycle"}, 32'(bus.best_cycle), ec);
   endtask

   vec_t tbl[6];
   int   bv0;
   bit   need_first;
   logic [63:0] rsc;

   initial begin
      tbl[0] = '{8'hFF, pk(3, 9, 2, 9, 1, 0, 5, 4), 9, 1};
      tbl[1] = '{8'hEF, pk(200, 200, 200, 200, 250, 200, 200, 200), 200, 0};
      tbl[2] = '{8'h00, fill(77), 0, 0};
      tbl[3] = '{8'hFF, pk(5, 5, 5, 5, 5, 5, 5, 6), 6, 7};
      tbl[4] = '{8'hFF, fill(255), 255, 0};
      tbl[5] = '{8'h7F, pk(1, 2, 3, 4, 5, 6, 7, 8), 7, 6};

      rst = 1'b1;
      bus.in_valid = 0; bus.in_first = 0; bus.in_last = 0;
      bus.lane_en = '0; bus.score = '0;
      model_reset();
      cycle(1, 0, 0, 0, 8'h00, 64'h0);
      idle();

      for (int i = 0; i < 6; i++) begin
         cycle(0, 1, 1, 1, tbl[i].en, tbl[i].sc);
         wait_result($sformatf("vec%0d", i), tbl[i].es, tbl[i].el, 0);
      end

      // 3-beat query with a bubble; pulse only after the last beat
      bv0 = bv_count;
      cycle(0, 1, 1, 0, 8'hFF, pk(1, 1, 1, 1, 1, 7, 1, 1));
      cycle(0, 1, 0, 0, 8'hFF, pk(3, 3, 12, 3, 3, 3, 3, 3));
      idle();
      cycle(0, 1, 0, 1, 8'hFF, pk(0, 0, 0, 0, 0, 0, 12, 0));
      wait_result("q3", 12, 2, 1);
      cmp("q3_pulses", 32'(bv_count - bv0), 1);

      // abandoned query, then single-beat query
      bv0 = bv_count;
      cycle(0, 1, 1, 0, 8'hFF, pk(50, 1, 1, 1, 1, 1, 1, 1));
      cycle(0, 1, 0, 0, 8'hFF, pk(1, 50, 1, 1, 1, 1, 1, 1));
      cycle(0, 1, 1, 1, 8'hFF, pk(2, 2, 2, 10, 2, 2, 2, 2));
      wait_result("abandon", 10, 3, 0);
      for (int i = 0; i < 4; i++) idle();
      cmp("abandon_pulses", 32'(bv_count - bv0), 1);

      // back-to-back single-beat queries
      cycle(0, 1, 1, 1, 8'hFF, pk(1, 1, 1, 1, 1, 1, 1, 20));
      cycle(0, 1, 1, 1, 8'hFF, pk(30, 1, 1, 1, 1, 1, 1, 1));
      wait_result("b2b_a", 20, 7, 0);
      idle();
      cmp("b2b_b_pulse", 32'(seen_bv), 1);
      cmp("b2b_b_score", 32'(bus.best_score), 30);

      // reset two cycles after the last beat is sampled
      bv0 = bv_count;
      cycle(0, 1, 1, 1, 8'hFF, pk(1, 1, 1, 1, 1, 99, 1, 1));
      idle();
      cycle(1, 0, 0, 0, 8'h00, 64'h0);
      idle();
      cmp("rst_score", 32'(bus.best_score), 0);
      cmp("rst_lane", 32'(bus.best_lane), 0);
      cmp("rst_cycle", 32'(bus.best_cycle), 0);
      cmp("rst_busy", 32'(bus.busy), 0);
      for (int i = 0; i < 5; i++) idle();
      cmp("rst_pulses", 32'(bv_count - bv0), 0);

      // 20-beat query, max at beat 18: beat counter saturates
      for (int b = 0; b < 20; b++)
         cycle(0, 1, b == 0, b == 19, 8'hFF, (b == 18) ? pk(1, 1, 1, 1, 100, 1, 1, 1) : fill(1));
      wait_result("sat", 100, 4, 15);

      need_first = 1;
      for (int n = 0; n < 400; n++) begin
         bit r, v, f, l;
         r = ($urandom_range(0, 99) == 0);
         v = ($urandom_range(0, 3) != 0);
         f = ($urandom_range(0, 6) == 0) || need_first;
         l = ($urandom_range(0, 6) == 0);
         for (int i = 0; i < NP; i++)
            rsc[i*8 +: 8] = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 3))
                                                        : 8'($urandom_range(0, 255));
         cycle(r, v, f, l, 8'($urandom), rsc);
         if (r) need_first = 1;
         else if (v && f) need_first = 0;
      end
      for (int i = 0; i < 6; i++) idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
